// File: rtl/bus_frame_tx.sv
// -----------------------------------------------------------------------------
// bus_frame_tx
//
// Serial bus-frame transmitter. Requests {cmd, addr, data} are queued in a
// small FIFO and sent MSB first on a single line as:
//   start(0) | cmd | addr | data | parity | stop(1) | optional idle-high gap
// Each bit is held for CLK_DIV clocks. With no gap, a queued frame starts on
// the clock right after the previous stop bit, so frames can run back to back.
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   request valid; a push happens when req_ready_o is also high
//   req_ready_o   FIFO not full
//   req_cmd_i     command field
//   req_addr_i    address field
//   req_data_i    data field
//   tx_en_i       permits starting new frames (checked only at a frame start)
//   tx_o          serial line, idles high
//   busy_o        high from frame pop through the stop bit and any gap bits
//   frame_done_o  one-clock pulse in the last clock of the stop bit
//   fifo_level_o  FIFO occupancy
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | line high, waiting for a queued request and tx_en_i
//   S_START  | start bit (0)
//   S_CMD    | command bits, MSB first
//   S_ADDR   | address bits, MSB first
//   S_DATA   | data bits, MSB first
//   S_PARITY | parity over {cmd, addr, data}
//   S_STOP   | stop bit (1); frame_done_o in its last clock
//   S_GAP    | idle-high gap of GAP_BITS bit periods
// -----------------------------------------------------------------------------
module bus_frame_tx #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 2,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0,
    parameter int GAP_BITS   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [CMD_WIDTH-1:0]              req_cmd_i,
    input  logic [ADDR_WIDTH-1:0]             req_addr_i,
    input  logic [DATA_WIDTH-1:0]             req_data_i,
    input  logic                              tx_en_i,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic                              frame_done_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);

    localparam int FRAME_WIDTH   = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH + 3;
    localparam int PAYLOAD_WIDTH = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    // The start bit is driven directly on load; the register holds the rest.
    localparam int SHIFT_WIDTH   = FRAME_WIDTH - 1;
    localparam int LEVEL_WIDTH   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_WIDTH     = $clog2(FIFO_DEPTH);
    localparam int DIV_WIDTH     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int MAX_CA        = (CMD_WIDTH > ADDR_WIDTH) ? CMD_WIDTH : ADDR_WIDTH;
    localparam int MAX_CAD       = (MAX_CA > DATA_WIDTH) ? MAX_CA : DATA_WIDTH;
    localparam int MAX_FIELD     = (MAX_CAD > GAP_BITS) ? MAX_CAD : GAP_BITS;
    localparam int CNT_WIDTH     = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;

    localparam logic [DIV_WIDTH-1:0] DIV_LOAD  = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CMD_LOAD  = CNT_WIDTH'(CMD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ADDR_LOAD = CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LOAD = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_CMD    = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;
    localparam logic [2:0] S_GAP    = 3'd7;

    // ---------------------------------------------------------------- FIFO
    logic [PAYLOAD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr;
    logic [PTR_WIDTH-1:0]     rd_ptr;
    logic [LEVEL_WIDTH-1:0]   fifo_level;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [PAYLOAD_WIDTH-1:0] head;
    logic                     head_parity;

    assign fifo_full    = (fifo_level == LEVEL_WIDTH'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_level == '0);
    assign req_ready_o  = !fifo_full;
    assign fifo_level_o = fifo_level;
    // Ready depends only on full, so a pop in the same cycle never frees a slot.
    assign push         = req_valid_i && !fifo_full;
    assign head         = fifo_mem[rd_ptr];
    assign head_parity  = (^head) ^ (PARITY_ODD != 0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_cmd_i, req_addr_i, req_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_WIDTH'(1);
                2'b01:   fifo_level <= fifo_level - LEVEL_WIDTH'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------------------------------------------------- serialiser
    logic [2:0]             state;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic [SHIFT_WIDTH-1:0] shreg;
    logic                   bit_end;
    logic                   field_end;
    logic                   tail_end;
    logic                   start_frame;

    assign bit_end   = (div_cnt == '0);
    assign field_end = bit_end && (bit_cnt == '0);
    // Last clock of the frame (stop bit when there is no gap, else the gap):
    // a new frame may be launched here so no idle clock is inserted.
    assign tail_end  = field_end &&
                       (((state == S_STOP) && (GAP_BITS == 0)) || (state == S_GAP));
    assign start_frame = !fifo_empty && tx_en_i && ((state == S_IDLE) || tail_end);
    assign pop         = start_frame;

    assign busy_o       = (state != S_IDLE);
    assign frame_done_o = (state == S_STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            tx_o    <= 1'b1;
        end else if (start_frame) begin
            state   <= S_START;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
            shreg   <= {head, head_parity, 1'b1};
            tx_o    <= 1'b0;
        end else if (state != S_IDLE) begin
            if (!bit_end) begin
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            end else begin
                div_cnt <= DIV_LOAD;
                // Ones are shifted in, so once the stop bit has gone out the
                // line naturally stays high through the gap and into idle.
                tx_o    <= shreg[SHIFT_WIDTH-1];
                shreg   <= {shreg[SHIFT_WIDTH-2:0], 1'b1};
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - CNT_WIDTH'(1);
                end else begin
                    case (state)
                        S_START: begin
                            state   <= S_CMD;
                            bit_cnt <= CMD_LOAD;
                        end
                        S_CMD: begin
                            state   <= S_ADDR;
                            bit_cnt <= ADDR_LOAD;
                        end
                        S_ADDR: begin
                            state   <= S_DATA;
                            bit_cnt <= DATA_LOAD;
                        end
                        S_DATA: begin
                            state   <= S_PARITY;
                            bit_cnt <= '0;
                        end
                        S_PARITY: begin
                            state   <= S_STOP;
                            bit_cnt <= '0;
                        end
                        S_STOP: begin
                            if (GAP_BITS > 0) begin
                                state   <= S_GAP;
                                bit_cnt <= GAP_LOAD;
                            end else begin
                                state   <= S_IDLE;
                                bit_cnt <= '0;
                            end
                        end
                        default: begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_frame_tx.sv
// -----------------------------------------------------------------------------
// Bench for bus_frame_tx. Three instances with different configurations:
//   dut0: CLK_DIV=4, even parity, no gap
//   dut1: CLK_DIV=4, odd parity, GAP_BITS=2
//   dut2: CLK_DIV=1, even parity, no gap
// The stimulus pushes the expected frame of every accepted request into a
// per-instance queue. A reference model pops a frame whenever it decides a
// frame starts, tracking time into the frame as a plain clock count; the
// monitor compares every output of every instance each clock.
// -----------------------------------------------------------------------------
module tb_bus_frame_tx;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int FW    = 27;

    logic       clk;
    logic       rst_n;
    logic       valid  [N];
    logic [1:0] cmd    [N];
    logic [13:0] addr  [N];
    logic [7:0] data   [N];
    logic       tx_en  [N];
    logic       ready  [N];
    logic       tx     [N];
    logic       busy   [N];
    logic       done   [N];
    logic [2:0] level  [N];

    int vectors;
    int miscompares;
    int wd_cnt;
    int wd_seen;

    // reference model state
    logic [FW-1:0] q0[$];
    logic [FW-1:0] q1[$];
    logic [FW-1:0] q2[$];
    logic [FW-1:0] cur  [N];
    int            cnt  [N];   // clocks into current frame+gap, -1 when idle
    int            mlev [N];

    bus_frame_tx #(.CLK_DIV(4), .PARITY_ODD(0), .GAP_BITS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_cmd_i(cmd[0]), .req_addr_i(addr[0]), .req_data_i(data[0]),
        .tx_en_i(tx_en[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .frame_done_o(done[0]), .fifo_level_o(level[0]));

    bus_frame_tx #(.CLK_DIV(4), .PARITY_ODD(1), .GAP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_cmd_i(cmd[1]), .req_addr_i(addr[1]), .req_data_i(data[1]),
        .tx_en_i(tx_en[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .frame_done_o(done[1]), .fifo_level_o(level[1]));

    bus_frame_tx #(.CLK_DIV(1), .PARITY_ODD(0), .GAP_BITS(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[2]), .req_ready_o(ready[2]),
        .req_cmd_i(cmd[2]), .req_addr_i(addr[2]), .req_data_i(data[2]),
        .tx_en_i(tx_en[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .frame_done_o(done[2]), .fifo_level_o(level[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int gap_of(int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int total_of(int k);
        return (FW + gap_of(k)) * div_of(k);
    endfunction

    function automatic logic [FW-1:0] frame_of(int k, logic [1:0] c, logic [13:0] a,
                                               logic [7:0] d);
        logic p;
        p = ^{c, a, d};
        if (k == 1) p = ~p;
        return {1'b0, c, a, d, p, 1'b1};
    endfunction

    function automatic void q_push(int k, logic [FW-1:0] f);
        case (k)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endfunction

    function automatic logic [FW-1:0] q_pop(int k);
        logic [FW-1:0] f;
        f = '1;
        case (k)
            0:       if (q0.size() > 0) f = q0.pop_front();
            1:       if (q1.size() > 0) f = q1.pop_front();
            default: if (q2.size() > 0) f = q2.pop_front();
        endcase
        return f;
    endfunction

    function automatic bit model_start(int k);
        return ((cnt[k] < 0) || (cnt[k] == total_of(k) - 1)) && (mlev[k] > 0) && tx_en[k];
    endfunction

    function automatic bit model_push(int k);
        return valid[k] && (mlev[k] < DEPTH);
    endfunction

    function automatic logic exp_tx(int k);
        int b;
        if (cnt[k] < 0) return 1'b1;
        b = cnt[k] / div_of(k);
        if (b >= FW) return 1'b1;
        return cur[k][FW-1-b];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                cnt[k]  <= -1;
                mlev[k] <= 0;
                cur[k]  <= '1;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (model_start(k)) begin
                    cnt[k] <= 0;
                    cur[k] <= q_pop(k);
                end else if (cnt[k] >= 0) begin
                    cnt[k] <= (cnt[k] == total_of(k) - 1) ? -1 : cnt[k] + 1;
                end
                mlev[k] <= mlev[k] + (model_push(k) ? 1 : 0) - (model_start(k) ? 1 : 0);
            end
        end
    end

    task automatic check(string name, int k, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            check("tx_o",         k, int'(tx[k]),    int'(exp_tx(k)));
            check("busy_o",       k, int'(busy[k]),  int'(cnt[k] >= 0));
            check("frame_done_o", k, int'(done[k]),  int'(cnt[k] == FW * div_of(k) - 1));
            check("fifo_level_o", k, int'(level[k]), mlev[k]);
            check("req_ready_o",  k, int'(ready[k]), int'(mlev[k] < DEPTH));
        end
        check("drain_timeout", 0, wd_cnt, wd_seen);
        wd_seen <= wd_cnt;
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int k, bit v, logic [1:0] c, logic [13:0] a, logic [7:0] d);
        valid[k] = v;
        cmd[k]   = c;
        addr[k]  = a;
        data[k]  = d;
        if (v && (mlev[k] < DEPTH)) q_push(k, frame_of(k, c, a, d));
    endtask

    task automatic drive_rand(int k, bit v);
        drive(k, v, 2'($urandom), 14'($urandom), 8'($urandom));
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < N; k++) valid[k] = 1'b0;
    endtask

    task automatic set_tx_en(bit v);
        for (int k = 0; k < N; k++) tx_en[k] = v;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < N; k++) begin
            if (cnt[k] >= 0 || mlev[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int i;
        i = 0;
        while (!all_idle() && i < 3000) begin
            tick();
            i++;
        end
        if (!all_idle()) begin
            $display("FAIL drain: not idle after %0d clocks, expected idle", i);
            wd_cnt++;
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wd_cnt      = 0;
        wd_seen     = 0;
        rst_n       = 1'b0;
        for (int k = 0; k < N; k++) begin
            valid[k] = 1'b0;
            cmd[k]   = '0;
            addr[k]  = '0;
            data[k]  = '0;
            tx_en[k] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single directed frame on every instance (even, odd, one clock per bit)
        set_tx_en(1'b1);
        for (int k = 0; k < N; k++) drive(k, 1'b1, 2'b01, 14'h1234, 8'hA5);
        tick();
        idle_inputs();
        drain();

        // data change flips even parity
        drive(0, 1'b1, 2'b01, 14'h1234, 8'hA4);
        tick();
        idle_inputs();
        drain();

        // fill past full with transmission held off, then release
        set_tx_en(1'b0);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) drive_rand(k, 1'b1);
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        set_tx_en(1'b1);
        drain();

        // reset in the middle of the address field, then a clean frame
        drive(0, 1'b1, 2'b10, 14'h2A5C, 8'h3C);
        tick();
        idle_inputs();
        repeat (30) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        drive(0, 1'b1, 2'b11, 14'h0F0F, 8'h81);
        tick();
        idle_inputs();
        drain();

        // one clock per bit: drop tx_en in the data field with a frame queued
        drive(2, 1'b1, 2'b00, 14'h3FFF, 8'h55);
        tick();
        drive(2, 1'b1, 2'b11, 14'h0001, 8'hFE);
        tick();
        idle_inputs();
        repeat (18) tick();
        tx_en[2] = 1'b0;
        repeat (40) tick();
        tx_en[2] = 1'b1;
        drain();

        // random traffic with occasional tx_en toggling
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                drive_rand(k, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 15) == 0) tx_en[k] = ~tx_en[k];
            end
            tick();
        end
        idle_inputs();
        set_tx_en(1'b1);
        drain();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_frame_tx.md
Name: bus_frame_tx

Overview:
Parametrised serial bus-frame transmitter, the successor to the fixed 27-bit frame format. It accepts {cmd, addr, data} requests over a valid/ready port into an internal FIFO. Each request is serialised as a start / cmd / addr / data / parity / stop frame on a single line, with a programmable bit period. It sits between a bus master's request logic and the serial link to the slave side.

Parameters:
- ADDR_WIDTH, 14, address field width (>=1).
- DATA_WIDTH, 8, data field width (>=1).
- CMD_WIDTH, 2, command field width (>=1).
- CLK_DIV, 4, clk cycles per serial bit (>=1).
- FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- GAP_BITS, 0, idle-high bit periods inserted between frames (>=0).
- Derived localparam: FRAME_WIDTH = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH + 3. With defaults this is 27.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid_i, in, 1, request valid.
- req_ready_o, out, 1, FIFO can accept a request; equals !full.
- req_cmd_i, in, CMD_WIDTH, command.
- req_addr_i, in, ADDR_WIDTH, address.
- req_data_i, in, DATA_WIDTH, data.
- tx_en_i, in, 1, permits starting new frames.
- tx_o, out, 1, serial line; idles high.
- busy_o, out, 1, high from frame pop through the end of the stop bit and any gap bits.
- frame_done_o, out, 1, one-cycle pulse at the end of the stop bit.
- fifo_level_o, out, $clog2(FIFO_DEPTH+1), FIFO occupancy.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: tx_o=1, busy_o=0, frame_done_o=0, fifo_level_o=0, req_ready_o=1. FSM goes to IDLE, FIFO is emptied, bit counter and divider are cleared.
- Reset mid-frame: the frame is abandoned immediately and tx_o returns to 1. FIFO contents are lost.
- Push rule: a push occurs on an edge with req_valid_i && req_ready_o. req_ready_o is purely !full, so no push is accepted when full, even if a pop happens in the same cycle.
- Simultaneous push and pop (not full): level is unchanged and both take effect.
- Frame bit order, MSB first: start(0), cmd[CMD_WIDTH-1:0], addr, data, parity, stop(1).
- Parity: even = ^{cmd, addr, data}. Odd = the inverse of that.
- FSM states: IDLE, START, CMD, ADDR, DATA, PARITY, STOP, GAP.
- IDLE: if FIFO non-empty and tx_en_i=1, pop and load the shift register, then enter START. tx_o=0 is registered on that same edge.
- Latency: a request pushed at edge E0 into an empty, idle block drives tx_o=0 from edge E0+1. First-word latency is one clock.
- Bit timing: each bit is held exactly CLK_DIV clocks; the divider counts CLK_DIV-1 down to 0. The field bit counter advances START -> CMD (CMD_WIDTH bits) -> ADDR -> DATA -> PARITY -> STOP.
- Frame length: FRAME_WIDTH*CLK_DIV clocks.
- frame_done_o: asserted in the last clk of the stop bit.
- End of STOP: if GAP_BITS>0, enter GAP and hold tx_o=1 for GAP_BITS*CLK_DIV clocks. Then return to IDLE evaluation.
- Back-to-back frames: with GAP_BITS=0, the next start bit begins on the edge after the last stop clock if FIFO non-empty and tx_en_i=1. This is zero idle clocks between frames.
- tx_en_i: sampled only when about to start a frame. Deasserting it mid-frame has no effect; the current frame and its gap complete.
- CLK_DIV=1: one bit per clock, and frame_done_o coincides with the single stop clock.
- busy_o: 1 in every state except IDLE.
- Widths: fifo_level_o never exceeds FIFO_DEPTH. FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Defaults, single request cmd=2'b01, addr=14'h1234, data=8'hA5 -> tx_o sequence 0, 01, 01001000110100, 10100101, parity 0, 1. Each bit lasts 4 clks, total 108 clks. frame_done_o pulses once; start bit begins one clk after the push.
2. Same request with PARITY_ODD=1 -> parity bit=1 and all other bits identical. Repeat with data=8'hA4 in even mode -> parity=1.
3. Push 6 requests back-to-back with FIFO_DEPTH=4 and tx_en_i=0 -> 4 accepted, fifo_level_o=4, req_ready_o=0. Raise tx_en_i -> 4 frames transmitted with no idle clocks between them (GAP_BITS=0), and fifo_level_o decrements at each frame start.
4. GAP_BITS=2, two queued frames -> tx_o high for exactly 8 clks between stop end and the next start bit. busy_o stays high throughout the gap.
5. Assert rst_n=0 in the middle of the ADDR field -> tx_o=1, busy_o=0, fifo_level_o=0 immediately (asynchronously). Release and push one request -> a correct frame is sent.
6. CLK_DIV=1, drop tx_en_i during DATA -> the current frame finishes in 27 clks and the next queued frame does not start until tx_en_i=1.
